// File: rtl/sd_crc16_if.sv
// ---------------------------------------------------------------------------
// sd_crc16_if
// Bundle of signals between the SD data serial host and one per-DAT-line
// CRC-16 engine.
//   bitval : host -> crc   serial data bit to fold into the CRC
//   enable : host -> crc   1 = shift bitval in on this sd_clk edge, 0 = hold
//   clr    : host -> crc   synchronous clear to INIT (SD_CRC16_SYNC_CLR_EN only)
//   crc    : crc -> host   current 16-bit CRC register (crc[15] sent first)
// Modports: master (host side), slave (CRC engine side).
// Build option: define SD_CRC16_SYNC_CLR_EN to add the clr signal.
// ---------------------------------------------------------------------------
interface sd_crc16_if;
  logic        bitval;
  logic        enable;
`ifdef SD_CRC16_SYNC_CLR_EN
  logic        clr;
`endif
  logic [15:0] crc;

`ifdef SD_CRC16_SYNC_CLR_EN
  modport master (output bitval, output enable, output clr, input  crc);
  modport slave  (input  bitval, input  enable, input  clr, output crc);
`else
  modport master (output bitval, output enable, input  crc);
  modport slave  (input  bitval, input  enable, output crc);
`endif
endinterface

// File: rtl/sd_crc16.sv
// ---------------------------------------------------------------------------
// sd_crc16
// Bit-serial CRC-16 (CCITT, x^16+x^12+x^5+1) generator/checker for one SD
// DAT line, MSB-first. The host shifts the block's data bits in with enable=1
// and then reads the CRC out of crc[15] first; on reads it compares the
// received CRC the same way. Block length is entirely host-controlled.
// Parameters:
//   POLY : feedback polynomial without the implicit x^16 term
//   INIT : register value after reset / clear
// Ports:
//   sd_clk : SD clock, register updates on the rising edge
//   rst    : asynchronous active-high clear (crc <= INIT)
//   bus    : sd_crc16_if.slave (bitval, enable, [clr], crc)
// Build option: SD_CRC16_SYNC_CLR_EN adds bus.clr, a synchronous clear that
// takes priority over enable. rst still clears asynchronously either way.
// ---------------------------------------------------------------------------
module sd_crc16 #(
  parameter logic [15:0] POLY = 16'h1021,
  parameter logic [15:0] INIT = 16'h0000
) (
  input  logic        sd_clk,
  input  logic        rst,
  sd_crc16_if.slave   bus
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // One LFSR step: feedback is the incoming bit XOR the outgoing MSB.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  endfunction

  // bitval is only looked at when enable=1, so an undriven/X bit during a
  // stall never reaches the register.
  always_comb begin
    crc_d = crc_q;
`ifdef SD_CRC16_SYNC_CLR_EN
    if (bus.clr) begin
      crc_d = INIT;
    end else if (bus.enable) begin
      crc_d = crc_step(crc_q, bus.bitval);
    end
`else
    if (bus.enable) begin
      crc_d = crc_step(crc_q, bus.bitval);
    end
`endif
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign bus.crc = crc_q;

endmodule

// File: tb/tb_sd_crc16.sv
module tb_sd_crc16;

  logic sd_clk = 1'b0;
  logic rst    = 1'b1;

  sd_crc16_if bus ();

  sd_crc16 dut (
    .sd_clk (sd_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sd_clk = ~sd_clk;

  // Scoreboard: stimulus pushes expected values, monitor pops and compares.
  logic [15:0] exp_q[$];
  string       name_q[$];
  event        chk_ev;
  int          total = 0;
  int          bad   = 0;

  initial begin
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        logic [15:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        total++;
        if (bus.crc !== e) begin
          bad++;
          $display("FAIL %s: crc=0x%04h expected=0x%04h", n, bus.crc, e);
        end
      end
    end
  end

  task automatic expect_crc(input string n, input logic [15:0] v);
    exp_q.push_back(v);
    name_q.push_back(n);
    -> chk_ev;
    #0;
  endtask

  // Drive inputs after the falling edge, return 1 time unit after the rising edge.
  task automatic step(input logic b, input logic en);
    @(negedge sd_clk);
    bus.bitval = b;
    bus.enable = en;
    @(posedge sd_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge sd_clk);
    rst = 1'b1;
    bus.enable = 1'b0;
    @(negedge sd_clk);
    rst = 1'b0;
  endtask

  task automatic run_bits(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b1);
  endtask

  // Watchdog: the bench is purely clock-driven, but never let it hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1);
  end

  initial begin
    bus.bitval = 1'b0;
    bus.enable = 1'b0;
`ifdef SD_CRC16_SYNC_CLR_EN
    bus.clr    = 1'b0;
`endif
    repeat (2) @(negedge sd_clk);
    rst = 1'b0;
    #1;
    expect_crc("reset_state", 16'h0000);

    // Single 1 from zero loads the polynomial itself.
    step(1'b1, 1'b1);
    expect_crc("one_bit", 16'h1021);

    // Stall: random bitval with enable=0 must not move the register.
    for (int i = 0; i < 20; i++) begin
      step(1'($urandom_range(0, 1)), 1'b0);
      if (i == 9) expect_crc("hold_mid", 16'h1021);
    end
    expect_crc("hold_end", 16'h1021);

    step(1'b0, 1'b1);
    expect_crc("zero_after_one", 16'h2042);
    step(1'b0, 1'b1);
    expect_crc("shift2", 16'h4084);
    step(1'b0, 1'b1);
    expect_crc("shift3", 16'h8108);
    // MSB falls out with bitval=0: fb=1, 0x0210 ^ 0x1021.
    step(1'b0, 1'b1);
    expect_crc("msb_feedback", 16'h1231);

    // Asynchronous clear between clock edges.
    rst = 1'b1;
    #1;
    expect_crc("async_rst", 16'h0000);
    // enable ignored while rst is held across an edge.
    bus.bitval = 1'b1;
    bus.enable = 1'b1;
    @(posedge sd_clk);
    #1;
    expect_crc("rst_held", 16'h0000);
    @(negedge sd_clk);
    rst = 1'b0;
    bus.enable = 1'b0;
    // First enabled edge after reset starts fresh from INIT.
    step(1'b1, 1'b1);
    expect_crc("fresh_after_rst", 16'h1021);

    // Full block of zeros.
    do_reset();
    run_bits(1'b0, 4096);
    expect_crc("block_zeros", 16'h0000);

    // Full block of 0xFF bytes: SD reference CRC.
    do_reset();
    run_bits(1'b1, 4096);
    expect_crc("block_ones", 16'h7FA1);

    // Output holds the block CRC while the host stalls.
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    expect_crc("block_hold", 16'h7FA1);

    // Same block with stall cycles sprinkled in.
    do_reset();
    for (int i = 0; i < 4096; i++) begin
      step(1'b1, 1'b1);
      if (i % 512 == 7) step(1'b0, 1'b0);
    end
    expect_crc("block_ones_stalled", 16'h7FA1);

    // Partial block discarded by a mid-block reset.
    do_reset();
    run_bits(1'b1, 100);
    do_reset();
    expect_crc("partial_discarded", 16'h0000);
    run_bits(1'b1, 4096);
    expect_crc("block_after_abort", 16'h7FA1);

`ifdef SD_CRC16_SYNC_CLR_EN
    // Synchronous clear wins over enable.
    @(negedge sd_clk);
    bus.clr    = 1'b1;
    bus.enable = 1'b1;
    bus.bitval = 1'b1;
    @(posedge sd_clk);
    #1;
    expect_crc("sync_clr", 16'h0000);
    @(negedge sd_clk);
    bus.clr = 1'b0;
    step(1'b1, 1'b1);
    expect_crc("after_sync_clr", 16'h1021);
`endif

    #2;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
